// File: rtl/mdio_phy_responder.sv
// Clause 22 MDIO responder: oversamples MDC/MDIO on the system clock, decodes frames for PHY_ADDR,
// strobes writes out and serialises read data taken from an external register file.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter bit          ACCEPT_BCAST = 1'b0,
  parameter int unsigned PREAMBLE_MIN = 32,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_mdc,
  input  logic        io_mdioIn,
  output logic        io_mdioOut,
  output logic        io_mdioOutEn,
  output logic [4:0]  io_rdRegAddr,
  input  logic [15:0] io_rdData,
  output logic        io_wrValid,
  output logic [4:0]  io_wrRegAddr,
  output logic [15:0] io_wrData,
  output logic        io_frameErr
);

  localparam logic [5:0] PreMin = 6'(PREAMBLE_MIN);

  typedef enum logic [3:0] {
    StPre, StSt, StOp, StPhyad, StRegad, StTaR, StRdData, StTaW, StWrData, StSkip
  } state_e;

  logic [SYNC_STAGES-1:0] mdc_sync_q, mdio_sync_q;
  logic                   mdc_prev_q;
  logic                   bit_ev, bit_in, addr_match;

  state_e      state_q, state_d;
  logic [5:0]  pre_cnt_q, pre_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  phy_q, phy_d;
  logic [4:0]  reg_q, reg_d;
  logic [15:0] shift_q, shift_d;
  logic        ta_first_q, ta_first_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        wr_valid_q, wr_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        out_q, out_d;
  logic        oe_q, oe_d;

  // Synchronisers idle high so an MDC already high out of reset is not seen as a rising edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      mdc_sync_q  <= '1;
      mdio_sync_q <= '1;
      mdc_prev_q  <= 1'b1;
      state_q     <= StPre;
      pre_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      op_q        <= '0;
      phy_q       <= '0;
      reg_q       <= '0;
      shift_q     <= '0;
      ta_first_q  <= 1'b0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      out_q       <= 1'b1;
      oe_q        <= 1'b0;
    end else begin
      mdc_sync_q  <= {mdc_sync_q[SYNC_STAGES-2:0], io_mdc};
      mdio_sync_q <= {mdio_sync_q[SYNC_STAGES-2:0], io_mdioIn};
      mdc_prev_q  <= mdc_sync_q[SYNC_STAGES-1];
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      op_q        <= op_d;
      phy_q       <= phy_d;
      reg_q       <= reg_d;
      shift_q     <= shift_d;
      ta_first_q  <= ta_first_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_valid_q  <= wr_valid_d;
      frame_err_q <= frame_err_d;
      out_q       <= out_d;
      oe_q        <= oe_d;
    end
  end

  assign bit_ev     = mdc_sync_q[SYNC_STAGES-1] & ~mdc_prev_q;
  assign bit_in     = mdio_sync_q[SYNC_STAGES-1];
  assign addr_match = (phy_q == PHY_ADDR) || (ACCEPT_BCAST && (phy_q == 5'd0));

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    op_d        = op_q;
    phy_d       = phy_q;
    reg_d       = reg_q;
    shift_d     = shift_q;
    ta_first_d  = ta_first_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    out_d       = out_q;
    oe_d        = oe_q;
    if (bit_ev) begin
      case (state_q)
        StPre: begin
          if (bit_in) begin
            pre_cnt_d = (pre_cnt_q == 6'd63) ? 6'd63 : pre_cnt_q + 6'd1;
          end else begin
            pre_cnt_d = '0;
            if (pre_cnt_q >= PreMin) state_d = StSt;
          end
        end
        StSt: begin
          bit_cnt_d = '0;
          pre_cnt_d = '0;
          state_d   = bit_in ? StOp : StPre;
        end
        StOp: begin
          op_d = {op_q[0], bit_in};
          if (bit_cnt_q == 5'd1) begin
            state_d   = StPhyad;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        StPhyad: begin
          phy_d = {phy_q[3:0], bit_in};
          if (bit_cnt_q == 5'd4) begin
            state_d   = StRegad;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        StRegad: begin
          reg_d = {reg_q[3:0], bit_in};
          if (bit_cnt_q == 5'd4) begin
            bit_cnt_d = '0;
            if (!addr_match) begin
              state_d   = StSkip;
              bit_cnt_d = 5'd17;
            end else if (op_q == 2'b10) begin
              rd_addr_d = reg_d;
              state_d   = StTaR;
            end else if (op_q == 2'b01) begin
              state_d = StTaW;
            end else begin
              frame_err_d = 1'b1;
              state_d     = StSkip;
              bit_cnt_d   = 5'd17;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        StTaR: begin
          shift_d   = io_rdData;
          oe_d      = 1'b1;
          out_d     = 1'b0;
          bit_cnt_d = '0;
          state_d   = StRdData;
        end
        StRdData: begin
          // 16 events drive D15..D0; the 17th releases the pad.
          if (bit_cnt_q == 5'd16) begin
            oe_d      = 1'b0;
            out_d     = 1'b1;
            pre_cnt_d = bit_in ? 6'd1 : 6'd0;
            state_d   = StPre;
          end else begin
            out_d     = shift_q[15];
            shift_d   = {shift_q[14:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        StTaW: begin
          if (bit_cnt_q == 5'd0) begin
            ta_first_d = bit_in;
            bit_cnt_d  = 5'd1;
          end else if (ta_first_q && !bit_in) begin
            bit_cnt_d = '0;
            state_d   = StWrData;
          end else begin
            frame_err_d = 1'b1;
            bit_cnt_d   = 5'd15;
            state_d     = StSkip;
          end
        end
        StWrData: begin
          shift_d = {shift_q[14:0], bit_in};
          if (bit_cnt_q == 5'd15) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = reg_q;
            wr_data_d  = shift_d;
            pre_cnt_d  = '0;
            state_d    = StPre;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        StSkip: begin
          if (bit_cnt_q == 5'd0) begin
            pre_cnt_d = '0;
            state_d   = StPre;
          end else begin
            bit_cnt_d = bit_cnt_q - 5'd1;
          end
        end
        default: begin
          pre_cnt_d = '0;
          state_d   = StPre;
        end
      endcase
    end
  end

  always_comb begin
    io_mdioOut   = out_q;
    io_mdioOutEn = oe_q;
    io_rdRegAddr = rd_addr_q;
    io_wrValid   = wr_valid_q;
    io_wrRegAddr = wr_addr_q;
    io_wrData    = wr_data_q;
    io_frameErr  = frame_err_q;
  end

endmodule
